// File: rtl/phase_comp_reg_host_if.sv
// Bundle of the serial host pins and the phase compensator register-file port.
// master: the environment side (pin driver plus register file).
// slave:  the serial-to-parallel bridge.
interface phase_comp_reg_host_if #(
  parameter int NUM_W  = 4,
  parameter int DATA_W = 10
);
  logic              cs;
  logic              sdi_en;
  logic              sdi;
  logic [DATA_W-1:0] reg_read_data;
  logic [NUM_W-1:0]  reg_num;
  logic              reg_write_readb;
  logic [DATA_W-1:0] reg_load_data;
  logic              sdo;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output cs, sdi_en, sdi, reg_read_data,
    input  reg_num, reg_write_readb, reg_load_data, sdo, busy, done, err
  );

  modport slave (
    input  cs, sdi_en, sdi, reg_read_data,
    output reg_num, reg_write_readb, reg_load_data, sdo, busy, done, err
  );
endinterface

// File: rtl/phase_comp_reg_host.sv
// Serial host bridge for the phase compensator register access port.
// Frame: W/Rb bit, NUM_W register-number bits, then DATA_W data bits on writes,
// all MSB first. Writes end in a one-cycle load enable; reads capture the
// register and shift it out on sdo.
// Optional build macro PHASE_COMP_REG_HOST_PARITY_EN: write frames carry a
// trailing even-parity bit; a bad frame skips the commit and raises sticky err.
module phase_comp_reg_host #(
  parameter int NUM_W  = 4,
  parameter int DATA_W = 10
) (
  input  logic clk,
  input  logic reset,
  phase_comp_reg_host_if.slave bus
);
  // Counter must reach DATA_W to cover the parity bit position.
  localparam int CNT_W = $clog2(DATA_W + 2);

  typedef enum logic [2:0] {IDLE, HDR, WDATA, COMMIT, RCAPT, RDATA, HOLD} state_t;

  state_t            state, state_nx;
  logic              strobe;
  logic              last_hdr;
  logic              last_data;
  logic [CNT_W-1:0]  cnt;
  logic              wrb;
  // Shared shift register: header/write data in, captured read data out.
  logic [DATA_W-1:0] shf;
  logic [NUM_W-1:0]  reg_num_q;
  logic [DATA_W-1:0] load_q;
  logic              wr_c;
  logic              done_c;
  logic              busy_c;
  logic              sdo_c;
`ifdef PHASE_COMP_REG_HOST_PARITY_EN
  logic              par;
  logic              par_ok;
  logic              err_q;
`endif

  assign strobe    = bus.cs & bus.sdi_en;
  assign last_hdr  = strobe && (cnt == CNT_W'(NUM_W - 1));
  assign last_data = strobe && (cnt == CNT_W'(DATA_W - 1));
`ifdef PHASE_COMP_REG_HOST_PARITY_EN
  // Running XOR of all prior frame bits combined with the parity bit on sdi.
  assign par_ok    = ~(par ^ bus.sdi);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode; dropping cs always returns to IDLE
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (strobe) state_nx = HDR;
      HDR:    if (last_hdr) state_nx = wrb ? WDATA : RCAPT;
      WDATA: begin
`ifdef PHASE_COMP_REG_HOST_PARITY_EN
        if (strobe && cnt == CNT_W'(DATA_W)) state_nx = par_ok ? COMMIT : HOLD;
`else
        if (last_data) state_nx = COMMIT;
`endif
      end
      COMMIT: state_nx = HOLD;
      RCAPT:  state_nx = RDATA;
      RDATA:  if (last_data) state_nx = HOLD;
      HOLD:   state_nx = HOLD;
      default: state_nx = IDLE;
    endcase
    if (state != IDLE && !bus.cs) state_nx = IDLE;
  end

  // Output decode; the load enable exists only in COMMIT so it is never wider than a cycle
  always_comb begin
    wr_c   = 1'b0;
    done_c = 1'b0;
    busy_c = (state != IDLE);
    sdo_c  = 1'b0;
    unique case (state)
      COMMIT:  begin wr_c = 1'b1; done_c = 1'b1; end
      RCAPT:   done_c = 1'b1;
      RDATA:   sdo_c = shf[DATA_W-1];
      default: ;
    endcase
  end

  // Frame datapath: bit counting, shifting, register number / load data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_num_q <= '0;
      load_q    <= '0;
`ifdef PHASE_COMP_REG_HOST_PARITY_EN
      err_q     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: if (strobe) begin
          wrb <= bus.sdi;
          cnt <= '0;
`ifdef PHASE_COMP_REG_HOST_PARITY_EN
          par   <= bus.sdi;
          err_q <= 1'b0;
`endif
        end
        HDR: if (strobe) begin
          shf <= {shf[DATA_W-2:0], bus.sdi};
          cnt <= cnt + 1'b1;
`ifdef PHASE_COMP_REG_HOST_PARITY_EN
          par <= par ^ bus.sdi;
`endif
          if (last_hdr) begin
            reg_num_q <= {shf[NUM_W-2:0], bus.sdi};
            cnt       <= '0;
          end
        end
        WDATA: if (strobe) begin
`ifdef PHASE_COMP_REG_HOST_PARITY_EN
          if (cnt == CNT_W'(DATA_W)) begin
            if (par_ok) load_q <= shf;
            else        err_q  <= 1'b1;
          end else begin
            shf <= {shf[DATA_W-2:0], bus.sdi};
            cnt <= cnt + 1'b1;
            par <= par ^ bus.sdi;
          end
`else
          shf <= {shf[DATA_W-2:0], bus.sdi};
          cnt <= cnt + 1'b1;
          if (last_data) load_q <= {shf[DATA_W-2:0], bus.sdi};
`endif
        end
        RCAPT: begin
          shf <= bus.reg_read_data;
          cnt <= '0;
        end
        RDATA: if (strobe) begin
          shf <= {shf[DATA_W-2:0], 1'b0};
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.reg_num         = reg_num_q;
  assign bus.reg_load_data   = load_q;
  assign bus.reg_write_readb = wr_c;
  assign bus.done            = done_c;
  assign bus.busy            = busy_c;
  assign bus.sdo             = sdo_c;
`ifdef PHASE_COMP_REG_HOST_PARITY_EN
  assign bus.err             = err_q;
`else
  assign bus.err             = 1'b0;
`endif
endmodule

// File: tb/tb_phase_comp_reg_host.sv
// Self-checking bench for phase_comp_reg_host with a behavioural register file
// and commit/read scoreboards.
module tb_phase_comp_reg_host;
  localparam int NUM_W  = 4;
  localparam int DATA_W = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  phase_comp_reg_host_if #(.NUM_W(NUM_W), .DATA_W(DATA_W)) bus ();
  phase_comp_reg_host #(.NUM_W(NUM_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [NUM_W-1:0]  num;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t               wr_q[$];
  logic [DATA_W-1:0] rd_q[$];
  logic [DATA_W-1:0] regfile [16];
  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  int exp_done = 0;
  logic prev_wr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Register file model: combinational read, level load enable on clk
  assign bus.reg_read_data = regfile[bus.reg_num];
  always @(posedge clk) begin
    if (reset) begin
      regfile[0]  <= 10'h155;
      regfile[10] <= 10'h2A5;
      regfile[15] <= 10'h200;
    end else if (bus.reg_write_readb) begin
      regfile[bus.reg_num] <= bus.reg_load_data;
    end
  end

  // Commit monitor
  always @(negedge clk) begin
    wr_t e;
    if (!reset) begin
      if (bus.done) n_done++;
      if (bus.reg_write_readb) begin
        chk("wr_single_cycle", {31'd0, prev_wr}, 0);
        chk("commit_expected", {31'd0, wr_q.size() != 0}, 1);
        if (wr_q.size() != 0) begin
          e = wr_q.pop_front();
          chk("commit_num", 32'(bus.reg_num), 32'(e.num));
          chk("commit_data", 32'(bus.reg_load_data), 32'(e.data));
        end
      end
      prev_wr = bus.reg_write_readb;
    end else begin
      prev_wr = 1'b0;
    end
  end

  task automatic send_bit(input logic b);
    bus.cs = 1'b1; bus.sdi_en = 1'b1; bus.sdi = b;
    @(posedge clk); #1;
    bus.sdi_en = 1'b0; bus.sdi = 1'b0;
  endtask

  task automatic end_frame();
    bus.cs = 1'b0; bus.sdi_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic write_frame(input logic [NUM_W-1:0] num, input logic [DATA_W-1:0] data,
                             input logic bad);
    wr_t e;
    if (!bad) begin
      e.num = num; e.data = data;
      wr_q.push_back(e);
      exp_done++;
    end
    send_bit(1'b1);
    for (int i = NUM_W - 1; i >= 0; i--) send_bit(num[i]);
    for (int i = DATA_W - 1; i >= 0; i--) send_bit(data[i]);
`ifdef PHASE_COMP_REG_HOST_PARITY_EN
    begin
      logic p;
      p = 1'b1 ^ (^num) ^ (^data) ^ bad;
      send_bit(p);
    end
`endif
    // Keep strobing through COMMIT and HOLD: those strobes must be ignored
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clk);
    chk("busy_hold", {31'd0, bus.busy}, 1);
    end_frame();
    @(negedge clk);
    chk("busy_after_write", {31'd0, bus.busy}, 0);
  endtask

  task automatic read_frame(input logic [NUM_W-1:0] num, input logic [DATA_W-1:0] exp);
    logic [DATA_W-1:0] got;
    logic [DATA_W-1:0] want;
    rd_q.push_back(exp);
    exp_done++;
    send_bit(1'b0);
    for (int i = NUM_W - 1; i >= 0; i--) send_bit(num[i]);
    // Strobe during RCAPT is ignored; the first bit is then on sdo
    send_bit(1'b1);
    for (int i = DATA_W - 1; i >= 0; i--) begin
      @(negedge clk);
      got[i] = bus.sdo;
      send_bit(1'b0);
    end
    @(negedge clk);
    chk("sdo_after_read", {31'd0, bus.sdo}, 0);
    chk("busy_read_hold", {31'd0, bus.busy}, 1);
    want = rd_q.pop_front();
    chk("read_data", 32'(got), 32'(want));
    end_frame();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.cs = 1'b0; bus.sdi_en = 1'b0; bus.sdi = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_reg_num", 32'(bus.reg_num), 0);
    chk("rst_wr", {31'd0, bus.reg_write_readb}, 0);
    chk("rst_load", 32'(bus.reg_load_data), 0);
    chk("rst_sdo", {31'd0, bus.sdo}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_done", {31'd0, bus.done}, 0);
    chk("rst_err", {31'd0, bus.err}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset in the middle of WDATA
    send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    bus.cs = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_reg_num", 32'(bus.reg_num), 0);
    chk("mid_rst_load", 32'(bus.reg_load_data), 0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 0);
    chk("mid_rst_wr", {31'd0, bus.reg_write_readb}, 0);
    chk("mid_rst_done", {31'd0, bus.done}, 0);
    chk("mid_rst_sdo", {31'd0, bus.sdo}, 0);
    chk("mid_rst_err", {31'd0, bus.err}, 0);

    write_frame(4'd5, 10'h333, 1'b0);
    chk("err_clear_w5", {31'd0, bus.err}, 0);
    read_frame(4'd10, 10'h2A5);
    read_frame(4'd5, 10'h333);

    // Abort a write after 8 data bits
    send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    bus.cs = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_busy", {31'd0, bus.busy}, 0);
    chk("abort_reg_num", 32'(bus.reg_num), 6);
    chk("abort_load", 32'(bus.reg_load_data), 32'h333);
    @(posedge clk); #1;
    read_frame(4'd5, 10'h333);

    write_frame(4'd12, 10'h2C9, 1'b0);
    read_frame(4'd12, 10'h2C9);
    read_frame(4'd0, 10'h155);
    read_frame(4'd15, 10'h200);

`ifdef PHASE_COMP_REG_HOST_PARITY_EN
    write_frame(4'd3, 10'h001, 1'b1);
    chk("par_err_set", {31'd0, bus.err}, 1);
    write_frame(4'd3, 10'h001, 1'b0);
    chk("par_err_cleared", {31'd0, bus.err}, 0);
    read_frame(4'd3, 10'h001);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("done_count", 32'(n_done), 32'(exp_done));
    chk("pending_commits", 32'(wr_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/phase_comp_reg_host.md
# phase_comp_reg_host

Serial-to-parallel host bridge that drives the register access port of the phase compensator control block. It decodes framed serial commands into the port's register number, write/read-select and load-data signals. On writes it issues a single-cycle write commit. On reads it captures the returned register value and shifts it back out serially. It sits between the chip-level configuration pins/scan controller and the phase compensator register file.

## Interface
- NUM_W, 4, register number width (16 registers)
- DATA_W, 10, register data width
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- cs  input  1  frame enable, active-high; low aborts/ends frame
- sdi_en  input  1  bit strobe; sdi sampled and sdo advanced only on clk edges with cs & sdi_en
- sdi  input  1  serial data in, MSB first
- reg_read_data  input  DATA_W  read data returned by register file (combinational from reg_num)
- reg_num  output  NUM_W  register select
- reg_write_readb  output  1  1 = write (load enable), 0 = read
- reg_load_data  output  DATA_W  write data
- sdo  output  1  serial read data out, MSB first
- busy  output  1  high from first sampled bit until return to IDLE
- done  output  1  one-cycle pulse on write commit or read capture
- err  output  1  frame error flag (parity build only; tied 0 otherwise)

## Operation
- Frame: bit0 = W/Rb, bits1-4 = reg_num MSB first; write frames add DATA_W data bits MSB first.
- States: IDLE, HDR, WDATA, COMMIT, RCAPT, RDATA, HOLD.
- IDLE -> HDR on first strobe with cs high; bit captured as W/Rb.
- HDR: after 4 more strobes, reg_num updates on the edge sampling the last header bit. If W/Rb = 1 -> WDATA, else -> RCAPT.
- WDATA: shift DATA_W bits into a staging register. After the last bit: reg_load_data updates and state -> COMMIT.
- COMMIT: reg_write_readb = 1 for exactly one clk cycle; done pulses in the same cycle; next state HOLD.
- reg_write_readb is 0 in every state except COMMIT. The destination decodes write_readb = 1 as a level load enable, so it must never stay high longer than one cycle.
- RCAPT: one cycle with reg_write_readb = 0 and reg_num stable; reg_read_data loads the output shift register at the end of the cycle; done pulses; next state RDATA.
- RDATA: sdo = shift MSB. Each strobe shifts left with zero fill. After DATA_W strobes -> HOLD with sdo = 0.
- HOLD: further strobes are ignored; cs low -> IDLE.
- cs low in any non-IDLE state -> IDLE next cycle. No commit occurs, and reg_num/reg_load_data retain their last values.
- sdi_en without cs is ignored.

## Timing
- Reset values: reg_num 0, reg_write_readb 0, reg_load_data 0, sdo 0, busy 0, done 0, err 0, state IDLE.
- Reset is synchronous and overrides all else, including mid-frame and in COMMIT. A commit pulse asserted in the reset cycle is dropped.
- Write latency: reg_write_readb high the clk cycle immediately after the edge sampling the final bit.
- Read latency: the first sdo bit is valid 2 clk edges after the last header bit is sampled. The host must leave at least 2 clk cycles before the next strobe.
- Strobes arriving in COMMIT or RCAPT are ignored; they are not queued.
- Back-to-back frames require cs low for at least 1 clk cycle.

## Configuration
- PHASE_COMP_REG_HOST_PARITY_EN defined:
  - Write frames carry one extra even-parity bit after the data, covering all 1+NUM_W+DATA_W+1 bits.
  - Commit occurs only if parity is correct.
  - On mismatch, go to HOLD without commit and set err.
  - err is sticky until the first strobe of the next frame or reset.
  - Read frames are unchanged.
- Undefined: no parity bit; commit follows the final data bit directly; err constant 0.

## Test plan
- Reset mid-WDATA: assert reset for 1 cycle -> all outputs 0, state IDLE; the following write frame commits normally.
- Write frame 1,0101,1100110011 -> one-cycle reg_write_readb pulse with reg_num=5 and reg_load_data=0x333; destination R5 reads back 0x333.
- Read frame 0,1010 with R10=0x2A5 -> sdo over next 10 strobes = 1010100101.
- cs dropped after 8 data bits of a write -> no reg_write_readb pulse, busy low next cycle, registers unchanged.
- Strobe every clk cycle, including during COMMIT/RCAPT -> those strobes are ignored, and reg_write_readb is never high for 2 consecutive cycles.
- Parity build: write to reg 3 data 0x001 with wrong parity -> no commit and err = 1. The next correct frame clears err and commits.
